// File: rtl/sram_model_ws_if.sv
// Board-side pin bundle of the external SRAM model.
// Control, address and status pins; DQ stays a plain inout.
interface sram_model_ws_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 18
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  SRAM_CE_N;
  logic                  SRAM_OE_N;
  logic                  SRAM_WE_N;
  logic [NB-1:0]         SRAM_BE_N;
  logic [ADDR_WIDTH-1:0] SRAM_ADDR;
  logic                  SRAM_RDY;
  logic                  SRAM_ERR;

  modport master (
    output SRAM_CE_N,
    output SRAM_OE_N,
    output SRAM_WE_N,
    output SRAM_BE_N,
    output SRAM_ADDR,
    input  SRAM_RDY,
    input  SRAM_ERR
  );

  modport slave (
    input  SRAM_CE_N,
    input  SRAM_OE_N,
    input  SRAM_WE_N,
    input  SRAM_BE_N,
    input  SRAM_ADDR,
    output SRAM_RDY,
    output SRAM_ERR
  );
endinterface

// File: rtl/sram_model_ws.sv
// Async external SRAM model: byte lanes, read latency,
// ready flag and sticky protocol/range error.
module sram_model_ws #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 18,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_model_ws_if.slave        bus,
  inout  wire  [DATA_WIDTH-1:0] SRAM_DQ
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_req;
  logic                  wr_req;
  logic                  conflict;
  logic                  in_range;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] dq_out;
  logic                  drive;
  logic                  err_q;

  assign rd_req   = ~bus.SRAM_CE_N & ~bus.SRAM_OE_N
                  & bus.SRAM_WE_N;
  assign wr_req   = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
  assign conflict = wr_req & ~bus.SRAM_OE_N;
  assign in_range = 32'(bus.SRAM_ADDR) < DEPTH_U;
  assign idx      = bus.SRAM_ADDR[IW-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  // Memory has no reset: contents survive rst like a real chip.
  always_ff @(posedge clk) begin
    if (wr_req && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (!bus.SRAM_BE_N[i]) begin
          mem[idx][8*i +: 8] <= SRAM_DQ[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (((rd_req | wr_req) & ~in_range) | conflict) begin
      err_q <= 1'b1;
    end
  end

  if (READ_LATENCY == 0) begin : g_comb
    assign drive  = rd_req;
    assign dq_out = rd_word;
  end else begin : g_fsm
    typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      READ_DATA
    } state_t;

    localparam int CW = $clog2(READ_LATENCY + 1) + 1;
    localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  same;

    assign same = bus.SRAM_ADDR == addr_q;

    // Any address change under a read restarts the latency count.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= IDLE;
        cnt    <= '0;
        addr_q <= '0;
        data_q <= '0;
      end else if (wr_req || !rd_req) begin
        state <= IDLE;
      end else if (state == IDLE || !same) begin
        addr_q <= bus.SRAM_ADDR;
        cnt    <= CW'(1);
        if (READ_LATENCY == 1) begin
          state  <= READ_DATA;
          data_q <= rd_word;
        end else begin
          state <= READ_WAIT;
        end
      end else if (state == READ_WAIT) begin
        cnt <= cnt + 1'b1;
        if (cnt + 1'b1 == LAT) begin
          data_q <= rd_word;
          state  <= READ_DATA;
        end
      end
    end

    assign drive  = (state == READ_DATA) & rd_req & same;
    assign dq_out = data_q;
  end

  // Pin drive is combinational so it releases with CE/OE/WE.
  assign SRAM_DQ      = drive ? dq_out : {DATA_WIDTH{1'bz}};
  assign bus.SRAM_RDY = drive;
  assign bus.SRAM_ERR = err_q;
endmodule

// File: tb/tb_sram_model_ws.sv
// Bench for sram_model_ws: latency-2 and latency-0 builds
// driven together against an array-based reference.
module tb_sram_model_ws;
  localparam int DW    = 16;
  localparam int AW    = 18;
  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_model_ws_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sram_model_ws_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

  wire  [DW-1:0] dq;
  wire  [DW-1:0] dq0;
  logic [DW-1:0] tb_dq;
  logic          ce_n;
  logic          oe_n;
  logic          we_n;
  logic [1:0]    be_n;
  logic [AW-1:0] addr;

  assign dq  = !we_n ? tb_dq : {DW{1'bz}};
  assign dq0 = !we_n ? tb_dq : {DW{1'bz}};

  assign bus.SRAM_CE_N  = ce_n;
  assign bus.SRAM_OE_N  = oe_n;
  assign bus.SRAM_WE_N  = we_n;
  assign bus.SRAM_BE_N  = be_n;
  assign bus.SRAM_ADDR  = addr;
  assign bus0.SRAM_CE_N = ce_n;
  assign bus0.SRAM_OE_N = oe_n;
  assign bus0.SRAM_WE_N = we_n;
  assign bus0.SRAM_BE_N = be_n;
  assign bus0.SRAM_ADDR = addr;

  sram_model_ws #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq)
  );

  sram_model_ws #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .READ_LATENCY(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0)
  );

  logic [DW-1:0] mem_m [DEPTH];
  int            n_m;
  logic [AW-1:0] last_m;
  logic          err_m;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_now();
    return !ce_n && !oe_n && we_n;
  endfunction

  function automatic logic wr_now();
    return !ce_n && !we_n;
  endfunction

  function automatic logic [DW-1:0] exp_word();
    if (int'(addr) < DEPTH) return mem_m[addr[8:0]];
    return '0;
  endfunction

  // n_m counts consecutive edges holding one read address.
  task automatic model_edge();
    if (((rd_now() || wr_now()) && int'(addr) >= DEPTH) ||
        (wr_now() && !oe_n)) err_m = 1'b1;
    if (wr_now() && int'(addr) < DEPTH) begin
      for (int i = 0; i < 2; i++) begin
        if (!be_n[i]) mem_m[addr[8:0]][8*i +: 8] = tb_dq[8*i +: 8];
      end
    end
    if (rd_now()) begin
      if (n_m > 0 && addr == last_m) begin
        if (n_m < 1000) n_m++;
      end else begin
        n_m = 1;
      end
      last_m = addr;
    end else begin
      n_m = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    logic r;
    r = rd_now() && addr == last_m && n_m >= LAT;
    chk({tag, "_rdy"}, 32'(bus.SRAM_RDY), 32'(r));
    if (r) chk({tag, "_dq"}, 32'(dq), 32'(exp_word()));
    chk({tag, "_err"}, 32'(bus.SRAM_ERR), 32'(err_m));
    chk({tag, "_rdy0"}, 32'(bus0.SRAM_RDY), 32'(rd_now()));
    if (rd_now()) chk({tag, "_dq0"}, 32'(dq0), 32'(exp_word()));
    chk({tag, "_err0"}, 32'(bus0.SRAM_ERR), 32'(err_m));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic set_bus(input logic c, input logic o,
                         input logic w, input logic [1:0] b,
                         input int a, input logic [DW-1:0] d);
    ce_n  = c;
    oe_n  = o;
    we_n  = w;
    be_n  = b;
    addr  = AW'(a);
    tb_dq = d;
  endtask

  task automatic wr(input int a, input logic [1:0] b,
                    input logic [DW-1:0] d, input string tag);
    set_bus(1'b0, 1'b1, 1'b0, b, a, d);
    tick(tag);
  endtask

  task automatic rd(input int a);
    set_bus(1'b0, 1'b0, 1'b1, 2'b11, a, '0);
  endtask

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 17) return int'($urandom_range(0, 31));
    if (r == 17) return 88;
    if (r == 18) return 511;
    return ($urandom_range(0, 1) == 0) ? 512 : 600;
  endfunction

  initial begin
    n_m    = 0;
    last_m = '0;
    err_m  = 1'b0;
    rst    = 1'b0;
    set_bus(1'b1, 1'b1, 1'b1, 2'b11, 0, '0);
    #12;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < 32; a++) wr(a, 2'b00, DW'($urandom), "init");
    wr(88, 2'b00, DW'($urandom), "init");
    wr(511, 2'b00, DW'($urandom), "init");

    wr(5, 2'b00, 16'hBEEF, "t1_wr");
    rd(5);
    tick("t1_e1");
    chk("t1_rdy_e1", 32'(bus.SRAM_RDY), 32'd0);
    tick("t1_e2");
    chk("t1_rdy_e2", 32'(bus.SRAM_RDY), 32'd1);
    chk("t1_dq", 32'(dq), 32'h0000_BEEF);

    wr(5, 2'b10, 16'h1234, "t2_wr");
    rd(5);
    tick("t2_e1");
    tick("t2_e2");
    chk("t2_dq", 32'(dq), 32'h0000_BE34);

    wr(6, 2'b00, 16'h0006, "t3_wr");
    rd(5);
    tick("t3_e1");
    rd(6);
    #1;
    check_outs("t3_chg");
    tick("t3_e2");
    chk("t3_rdy_e2", 32'(bus.SRAM_RDY), 32'd0);
    tick("t3_e3");
    chk("t3_rdy_e3", 32'(bus.SRAM_RDY), 32'd1);
    chk("t3_dq", 32'(dq), 32'h0000_0006);
    oe_n = 1'b1;
    #1;
    chk("t3_oe_rel", 32'(bus.SRAM_RDY), 32'd0);
    check_outs("t3_oe");

    wr(600, 2'b00, 16'h5A5A, "t4_wr");
    chk("t4_err", 32'(bus.SRAM_ERR), 32'd1);
    rd(600);
    tick("t4_e1");
    tick("t4_e2");
    chk("t4_dq", 32'(dq), 32'd0);
    rd(88);
    tick("t4_alias1");
    tick("t4_alias2");

    set_bus(1'b0, 1'b0, 1'b0, 2'b00, 7, 16'hAAAA);
    #1;
    chk("t5_rdy", 32'(bus.SRAM_RDY), 32'd0);
    chk("t5_bus", 32'(dq), 32'h0000_AAAA);
    tick("t5_e1");
    rd(7);
    tick("t5_rd1");
    tick("t5_rd2");
    chk("t5_dq", 32'(dq), 32'h0000_AAAA);

    chk("t6_err_pre", 32'(bus.SRAM_ERR), 32'd1);
    rd(5);
    tick("t6_e1");
    rst   = 1'b0;
    n_m   = 0;
    err_m = 1'b0;
    #1;
    chk("t6_rst_rdy", 32'(bus.SRAM_RDY), 32'd0);
    chk("t6_rst_err", 32'(bus.SRAM_ERR), 32'd0);
    #2;
    rst = 1'b1;
    tick("t6_e2");
    chk("t6_rdy_e2", 32'(bus.SRAM_RDY), 32'd0);
    tick("t6_e3");
    chk("t6_dq", 32'(dq), 32'h0000_BE34);

    for (int i = 0; i < 400; i++) begin
      if (i == 0 || $urandom_range(0, 99) >= 55) begin
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 5) begin
          rd(pick_addr());
        end else if (k < 8) begin
          set_bus(1'b0, 1'b1, 1'b0, 2'($urandom),
                  pick_addr(), DW'($urandom));
        end else if (k == 8) begin
          set_bus(1'b0, 1'b0, 1'b0, 2'($urandom),
                  pick_addr(), DW'($urandom));
        end else begin
          set_bus(1'b1, 1'($urandom), 1'($urandom),
                  2'($urandom), pick_addr(), DW'($urandom));
        end
      end
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
